buzzer_arbiter: RTL and testbench
=================================

BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 1000000, giving the mute-gap length in clk cycles on a mode change (minimum 1).
REQ-002 The block SHALL have parameter NOTE_CYCLES, default 10000000, giving the hold time in clk cycles of each auto-play note (minimum 2).
REQ-003 clk  in  1  system clock; all state is updated on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mode_req  in  2  requested mode: 00 idle, 01 free, 10 auto, 11 learn.
REQ-006 mode_strobe  in  1  one-cycle pulse that requests a change to mode_req.
REQ-007 free_note  in  4  free-play note; free_octave  in  2  its octave.
REQ-008 learn_note  in  4  learn-mode note; learn_octave  in  2  its octave.
REQ-009 auto_note  in  4, auto_octave  in  2, auto_valid  in  1  auto-play note offer.
REQ-010 auto_ready  out  1  the block accepts auto_note/auto_octave on a cycle where auto_valid and auto_ready are both high.
REQ-011 note_to_play  out  4  note to the buzzer: 0 is silence, 1..7 are notes.
REQ-012 octave_out  out  2  octave to the buzzer.
REQ-013 led_out  out  7  one-hot note indicator.
REQ-014 active_mode  out  2  currently granted mode; busy  out  1  high during a mute gap.

Function
REQ-015 The state machine SHALL have the states IDLE, FREE, AUTO, LEARN and GAP; active_mode SHALL encode IDLE/FREE/AUTO/LEARN as 00/01/10/11.
REQ-016 A mode_strobe with mode_req equal to active_mode while not in GAP SHALL be ignored.
REQ-017 A mode_strobe with a different mode_req SHALL latch mode_req as the pending mode and enter GAP on the next cycle (when MUTE_GAP_EN is defined).
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles, then enter the pending mode; during GAP, busy is 1, note_to_play is 0 and auto_ready is 0.
REQ-019 A mode_strobe during GAP SHALL overwrite the pending mode and restart the gap count from zero.
REQ-020 IDLE SHALL drive note_to_play 0, octave_out 00 and auto_ready 0.
REQ-021 FREE and LEARN SHALL register the matching note and octave inputs, giving one cycle of latency from input to output.
REQ-022 On entry to AUTO, auto_ready SHALL go high and stay high until a handshake occurs; note_to_play is 0 while waiting.
REQ-023 On a handshake, the block SHALL drop auto_ready the next cycle and drive the latched note/octave for exactly NOTE_CYCLES cycles, then drive 0 and raise auto_ready again.
REQ-024 Leaving AUTO mid-note SHALL discard the held note and reset the hold counter.
REQ-025 A note input value of 8..15 SHALL be output as note_to_play 0, with octave passed through unchanged.
REQ-026 led_out SHALL equal 1<<(note_to_play-1) for notes 1..7 and 0 otherwise, updated in the same cycle as note_to_play.
REQ-027 The gap and hold counters SHALL be sized to hold GAP_CYCLES and NOTE_CYCLES without wrap.

Reset
REQ-028 While reset is 0, the block SHALL immediately force: state IDLE, pending mode 00, counters 0, note_to_play 0, octave_out 00, led_out 0, active_mode 00, busy 0, auto_ready 0.
REQ-029 Reset asserted mid-gap or mid-note SHALL abort that operation; there is no resume after release.
REQ-030 The first strobe after reset release SHALL be honoured.

Configuration
REQ-031 With BUZZER_ARB_MUTE_GAP_EN defined, mode changes SHALL pass through GAP as in REQ-017 to REQ-019.
REQ-032 Without BUZZER_ARB_MUTE_GAP_EN, a mode change SHALL enter the new mode on the cycle after the strobe; the GAP state, its counter and the busy logic are absent, and busy is tied to 0.

Verification
REQ-033 Macro on, GAP_CYCLES=4, FREE with free_note=3: strobe to learn -> busy=1 and note=0 for 4 cycles, then active_mode=11 and note=learn_note.
REQ-034 Strobe at gap cycle 2 with a new mode_req -> pending mode updated, and the gap ends 4 cycles after the second strobe.
REQ-035 AUTO, NOTE_CYCLES=3, auto_valid held high with notes 5 then 6 -> note 5 for 3 cycles, one cycle of 0 with auto_ready=1, then note 6.
REQ-036 FREE, free_note=4'b1111 -> note_to_play=0 and led_out=0; free_note=7 -> led_out=7'b1000000 one cycle later.
REQ-037 reset pulled low mid-note in AUTO -> all outputs are 0 asynchronously (before the next clk edge); after release, active_mode=00.
REQ-038 Macro off: strobe from FREE to AUTO -> active_mode=10 and auto_ready=1 on the next cycle, with busy never 1.

Source files
------------

// File: rtl/buzzer_arbiter.sv
// Buzzer mode arbiter: grants IDLE/FREE/AUTO/LEARN and drives note, octave and LED outputs.
// Define BUZZER_ARB_MUTE_GAP_EN to insert a muted GAP of GAP_CYCLES between mode changes.
module buzzer_arbiter #(
    parameter int unsigned GAP_CYCLES  = 1000000,
    parameter int unsigned NOTE_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_strobe,
    input  logic [3:0] free_note,
    input  logic [1:0] free_octave,
    input  logic [3:0] learn_note,
    input  logic [1:0] learn_octave,
    input  logic [3:0] auto_note,
    input  logic [1:0] auto_octave,
    input  logic       auto_valid,
    output logic       auto_ready,
    output logic [3:0] note_to_play,
    output logic [1:0] octave_out,
    output logic [6:0] led_out,
    output logic [1:0] active_mode,
    output logic       busy
);

    localparam int unsigned NOTE_W = $clog2(NOTE_CYCLES + 1);

    if (GAP_CYCLES < 1 || NOTE_CYCLES < 2) begin : g_bad_param
        $error("buzzer_arbiter: GAP_CYCLES must be >= 1 and NOTE_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FREE  = 3'd1,
        ST_AUTO  = 3'd2,
        ST_LEARN = 3'd3
`ifdef BUZZER_ARB_MUTE_GAP_EN
        , ST_GAP = 3'd4
`endif
    } state_t;

    // Notes 8..15 are not playable and collapse to silence.
    function automatic logic [3:0] f_san(input logic [3:0] n);
        return (n > 4'd7) ? 4'd0 : n;
    endfunction

    function automatic logic [6:0] f_led(input logic [2:0] n);
        logic [7:0] l;
        l = 8'(8'd1 << n);
        return l[7:1];
    endfunction

    state_t            r_state;
    logic [1:0]        r_active_mode;
    logic [3:0]        r_note;
    logic [1:0]        r_octave;
    logic [6:0]        r_led;
    logic              r_auto_ready;
    logic [NOTE_W-1:0] r_hold_cnt;

    logic [3:0] w_free_n, w_learn_n, w_auto_n;
    logic       w_change, w_enter, w_gap_start;
    logic [1:0] w_tgt;

    assign w_free_n  = f_san(free_note);
    assign w_learn_n = f_san(learn_note);
    assign w_auto_n  = f_san(auto_note);
    assign w_change  = mode_strobe && (mode_req != r_active_mode);

`ifdef BUZZER_ARB_MUTE_GAP_EN
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    logic [1:0]       r_pend;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_busy;

    // A strobe inside GAP restarts the count, so it takes priority over the exit.
    always_comb begin
        w_enter     = 1'b0;
        w_gap_start = 1'b0;
        w_tgt       = mode_req;
        if (r_state == ST_GAP) begin
            w_tgt   = r_pend;
            w_enter = !mode_strobe && (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
        end else begin
            w_gap_start = w_change;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend    <= 2'b00;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
        end else if (w_gap_start) begin
            r_pend    <= mode_req;
            r_gap_cnt <= '0;
            r_busy    <= 1'b1;
        end else if (w_enter) begin
            r_busy    <= 1'b0;
        end else if (r_state == ST_GAP) begin
            if (mode_strobe) begin
                r_pend    <= mode_req;
                r_gap_cnt <= '0;
            end else begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
        end
    end

    assign busy = r_busy;
`else
    always_comb begin
        w_gap_start = 1'b0;
        w_tgt       = mode_req;
        w_enter     = w_change;
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_active_mode <= 2'b00;
            r_note        <= 4'd0;
            r_octave      <= 2'b00;
            r_led         <= 7'd0;
            r_auto_ready  <= 1'b0;
            r_hold_cnt    <= '0;
        end else if (w_gap_start) begin
`ifdef BUZZER_ARB_MUTE_GAP_EN
            r_state      <= ST_GAP;
`endif
            r_note       <= 4'd0;
            r_octave     <= 2'b00;
            r_led        <= 7'd0;
            r_auto_ready <= 1'b0;
            r_hold_cnt   <= '0;
        end else if (w_enter) begin
            r_active_mode <= w_tgt;
            r_hold_cnt    <= '0;
            r_note        <= 4'd0;
            r_octave      <= 2'b00;
            r_led         <= 7'd0;
            r_auto_ready  <= 1'b0;
            case (w_tgt)
                2'b00: r_state <= ST_IDLE;
                2'b01: begin
                    r_state  <= ST_FREE;
                    r_note   <= w_free_n;
                    r_octave <= free_octave;
                    r_led    <= f_led(w_free_n[2:0]);
                end
                2'b10: begin
                    r_state      <= ST_AUTO;
                    r_auto_ready <= 1'b1;
                end
                default: begin
                    r_state  <= ST_LEARN;
                    r_note   <= w_learn_n;
                    r_octave <= learn_octave;
                    r_led    <= f_led(w_learn_n[2:0]);
                end
            endcase
        end else begin
            case (r_state)
                ST_FREE: begin
                    r_note   <= w_free_n;
                    r_octave <= free_octave;
                    r_led    <= f_led(w_free_n[2:0]);
                end
                ST_LEARN: begin
                    r_note   <= w_learn_n;
                    r_octave <= learn_octave;
                    r_led    <= f_led(w_learn_n[2:0]);
                end
                // auto_ready low means a note is being held for NOTE_CYCLES.
                ST_AUTO: begin
                    if (r_auto_ready) begin
                        if (auto_valid) begin
                            r_auto_ready <= 1'b0;
                            r_hold_cnt   <= '0;
                            r_note       <= w_auto_n;
                            r_octave     <= auto_octave;
                            r_led        <= f_led(w_auto_n[2:0]);
                        end
                    end else if (r_hold_cnt == NOTE_W'(NOTE_CYCLES - 1)) begin
                        r_auto_ready <= 1'b1;
                        r_note       <= 4'd0;
                        r_octave     <= 2'b00;
                        r_led        <= 7'd0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + NOTE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign auto_ready   = r_auto_ready;
    assign note_to_play = r_note;
    assign octave_out   = r_octave;
    assign led_out      = r_led;
    assign active_mode  = r_active_mode;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter (GAP_CYCLES=4, NOTE_CYCLES=3); follows BUZZER_ARB_MUTE_GAP_EN.
module tb_buzzer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_req;
    logic       mode_strobe;
    logic [3:0] free_note, learn_note, auto_note;
    logic [1:0] free_octave, learn_octave, auto_octave;
    logic       auto_valid;
    logic       auto_ready;
    logic [3:0] note_to_play;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [1:0] active_mode;
    logic       busy;

    buzzer_arbiter #(.GAP_CYCLES(4), .NOTE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .mode_strobe(mode_strobe),
        .free_note(free_note), .free_octave(free_octave),
        .learn_note(learn_note), .learn_octave(learn_octave),
        .auto_note(auto_note), .auto_octave(auto_octave), .auto_valid(auto_valid),
        .auto_ready(auto_ready), .note_to_play(note_to_play), .octave_out(octave_out),
        .led_out(led_out), .active_mode(active_mode), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] note;
        logic [1:0] oct;
        logic       chk_oct;
        logic [1:0] mode;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] tb_mode;

    always @(posedge clk) cyc++;

    function automatic logic [6:0] exp_led(input logic [3:0] n);
        case (n)
            4'd1: return 7'b0000001;
            4'd2: return 7'b0000010;
            4'd3: return 7'b0000100;
            4'd4: return 7'b0001000;
            4'd5: return 7'b0010000;
            4'd6: return 7'b0100000;
            4'd7: return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

    // Monitor: compare every expectation tagged with the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            exp_t s;
            s = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", s.name, s.cyc, cyc);
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            logic ok;
            e = q.pop_front();
            n_cmp++;
            ok = (note_to_play === e.note) && (led_out === exp_led(e.note)) &&
                 (active_mode === e.mode) && (busy === e.busy) && (auto_ready === e.ready) &&
                 (!e.chk_oct || (octave_out === e.oct));
            if (!ok) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got note=%0d oct=%0d led=%b mode=%0d busy=%b ready=%b; need note=%0d oct=%0d(chk=%0b) led=%b mode=%0d busy=%b ready=%b",
                         e.name, cyc, note_to_play, octave_out, led_out, active_mode, busy, auto_ready,
                         e.note, e.oct, e.chk_oct, exp_led(e.note), e.mode, e.busy, e.ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_now(input string nm, input logic [3:0] n, input logic [1:0] o,
                           input logic co, input logic [1:0] m, input logic b, input logic r);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.note = n; e.oct = o; e.chk_oct = co;
        e.mode = m; e.busy = b; e.ready = r;
        q.push_back(e);
    endtask

    // Strobe a mode change; with the mute gap, check the 4 silent busy cycles.
    task automatic strobe_to(input logic [1:0] m);
        mode_req    = m;
        mode_strobe = 1'b1;
        step();
        mode_strobe = 1'b0;
`ifdef BUZZER_ARB_MUTE_GAP_EN
        for (int i = 0; i < 4; i++) begin
            exp_now("gap", 4'd0, 2'd0, 1'b0, tb_mode, 1'b1, 1'b0);
            step();
        end
`endif
        tb_mode = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mode_req = 2'd0; mode_strobe = 1'b0;
        free_note = 4'd0; free_octave = 2'd0; learn_note = 4'd0; learn_octave = 2'd0;
        auto_note = 4'd0; auto_octave = 2'd0; auto_valid = 1'b0; tb_mode = 2'd0;

        step(); step();
        exp_now("reset_hold", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        exp_now("idle_after_rst", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);

        mode_req = 2'd0; mode_strobe = 1'b1; step(); mode_strobe = 1'b0;
        exp_now("idle_same_strobe", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);

        // FREE: one-cycle latency, out-of-range note, top note LED
        free_note = 4'd3; free_octave = 2'd2;
        strobe_to(2'd1);
        exp_now("free_entry", 4'd3, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
        free_note = 4'd15; free_octave = 2'd1;
        exp_now("free_latency", 4'd3, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
        step();
        exp_now("free_note15", 4'd0, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0);
        free_note = 4'd7; free_octave = 2'd3;
        step();
        exp_now("free_note7", 4'd7, 2'd3, 1'b1, 2'd1, 1'b0, 1'b0);

        // LEARN
        learn_note = 4'd5; learn_octave = 2'd1;
        strobe_to(2'd3);
        exp_now("learn_entry", 4'd5, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
        mode_req = 2'd3; mode_strobe = 1'b1; step(); mode_strobe = 1'b0;
        exp_now("learn_same_strobe", 4'd5, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
        learn_note = 4'd2;
        step();
        exp_now("learn_track", 4'd2, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);

`ifdef BUZZER_ARB_MUTE_GAP_EN
        // Re-strobe two cycles into the gap: new target, count restarts
        mode_req = 2'd1; mode_strobe = 1'b1; step(); mode_strobe = 1'b0;
        exp_now("gap_a0", 4'd0, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0);
        step();
        exp_now("gap_a1", 4'd0, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0);
        mode_req = 2'd0; mode_strobe = 1'b1; step(); mode_strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_now("gap_restart", 4'd0, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0);
            step();
        end
        exp_now("gap_to_idle", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        tb_mode = 2'd0;
`endif

        // AUTO: notes 5 then 6 with valid held high
        auto_valid = 1'b0;
        strobe_to(2'd2);
        exp_now("auto_entry", 4'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1);
        step();
        exp_now("auto_wait", 4'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1);
        auto_note = 4'd5; auto_octave = 2'd2; auto_valid = 1'b1;
        step();
        exp_now("auto_n5_c1", 4'd5, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0);
        auto_note = 4'd6; auto_octave = 2'd1;
        step();
        exp_now("auto_n5_c2", 4'd5, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0);
        step();
        exp_now("auto_n5_c3", 4'd5, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0);
        step();
        exp_now("auto_gap_slot", 4'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1);
        step();
        exp_now("auto_n6_c1", 4'd6, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0);
        auto_valid = 1'b0;
        step();
        exp_now("auto_n6_c2", 4'd6, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0);
        step();
        exp_now("auto_n6_c3", 4'd6, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0);
        step();
        exp_now("auto_release", 4'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1);

        // Leave AUTO mid-note, then return
        auto_note = 4'd2; auto_octave = 2'd0; auto_valid = 1'b1;
        step();
        exp_now("auto_n2", 4'd2, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        auto_valid = 1'b0;
        free_note = 4'd1; free_octave = 2'd0;
        strobe_to(2'd1);
        exp_now("free_after_auto", 4'd1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        strobe_to(2'd2);
        exp_now("auto_reentry", 4'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1);
        step();
        exp_now("auto_no_stale", 4'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1);

        // Async reset mid-note
        auto_note = 4'd6; auto_octave = 2'd1; auto_valid = 1'b1;
        step();
        exp_now("auto_pre_reset", 4'd6, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0);
        auto_valid = 1'b0;
        step();
        reset = 1'b0;
        exp_now("async_reset", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        exp_now("reset_held", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tb_mode = 2'd0;
        step();
        exp_now("post_reset_idle", 4'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);

        free_note = 4'd2; free_octave = 2'd1;
        strobe_to(2'd1);
        exp_now("first_strobe", 4'd2, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0);

        step(); step();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
